// File: rtl/fifo_pkg.sv
// Shared defaults and occupancy helper for the synchronous FIFO buffer.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int PTR_CALC_W     = 32;

  // Pointers are zero-extended into 32 bits; the result is masked back to the
  // (addr_width+1)-bit pointer modulus so wrap of the MSB is handled.
  function automatic logic [PTR_CALC_W-1:0] ptr_occupancy(
    input logic [PTR_CALC_W-1:0] wptr,
    input logic [PTR_CALC_W-1:0] rptr,
    input int unsigned           addr_width
  );
    logic [PTR_CALC_W-1:0] mask;
    mask = (PTR_CALC_W'(1) << (addr_width + 1)) - PTR_CALC_W'(1);
    return (wptr - rptr) & mask;
  endfunction

endpackage

// File: rtl/sync_ram_2p.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module sync_ram_2p #(
  parameter int WIDTH = 8,
  parameter int AW    = 9
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with registered read data, level flags and sticky
// overflow/underflow error flags.
module sync_fifo_buf
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic                  rinc,
  input  logic                  clr_err,
  output logic [FIFO_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_INC = {{ADDR_WIDTH{1'b0}}, 1'b1};

  if (AFULL_LVL > DEPTH || AEMPTY_LVL >= DEPTH || ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_params
    $error("sync_fifo_buf: illegal AFULL_LVL/AEMPTY_LVL/ADDR_WIDTH combination");
  end

  logic [ADDR_WIDTH:0]     r_wptr;
  logic [ADDR_WIDTH:0]     r_rptr;
  logic                    r_rvalid;
  logic                    r_rd_loaded;
  logic                    r_overflow;
  logic                    r_underflow;
  logic [PTR_CALC_W-1:0]   w_occ;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [FIFO_WIDTH-1:0]   w_ram_q;

  assign w_occ = ptr_occupancy({{(PTR_CALC_W-ADDR_WIDTH-1){1'b0}}, r_wptr},
                               {{(PTR_CALC_W-ADDR_WIDTH-1){1'b0}}, r_rptr},
                               ADDR_WIDTH);

  assign w_full   = (w_occ == PTR_CALC_W'(DEPTH));
  assign w_empty  = (w_occ == '0);
  assign w_wr_acc = winc && !w_full;
  assign w_rd_acc = rinc && !w_empty;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_rvalid    <= 1'b0;
      r_rd_loaded <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_INC;
      if (w_rd_acc) r_rptr <= r_rptr + PTR_INC;
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rd_loaded <= 1'b1;
      // A new error event takes priority over a same-cycle clear.
      if (winc && w_full)      r_overflow <= 1'b1;
      else if (clr_err)        r_overflow <= 1'b0;
      if (rinc && w_empty)     r_underflow <= 1'b1;
      else if (clr_err)        r_underflow <= 1'b0;
    end
  end

  sync_ram_2p #(
    .WIDTH (FIFO_WIDTH),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (wclk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (wdata),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_ram_q)
  );

  // The storage read register has no reset, so rdata is masked to zero until
  // the first read after reset has loaded it.
  assign rdata         = r_rd_loaded ? w_ram_q : '0;
  assign rvalid        = r_rvalid;
  assign count         = w_occ[ADDR_WIDTH:0];
  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (w_occ >= PTR_CALC_W'(AFULL_LVL));
  assign ralmost_empty = (w_occ <= PTR_CALC_W'(AEMPTY_LVL));
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Self-checking bench for sync_fifo_buf: directed and random traffic against a
// queue-based reference model.
module tb_sync_fifo_buf;

  localparam int W     = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          rvalid, wfull, rempty, walmost_full, ralmost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo_buf #(
    .FIFO_WIDTH (W),
    .ADDR_WIDTH (AW),
    .AFULL_LVL  (AF),
    .AEMPTY_LVL (AE)
  ) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .clr_err       (clr_err),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_rdata = '0;
  logic         m_rvalid = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_udf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".rdata"},   32'(rdata),         32'(m_rdata));
    chk({tag, ".rvalid"},  32'(rvalid),        32'(m_rvalid));
    chk({tag, ".count"},   32'(count),         32'(n));
    chk({tag, ".wfull"},   32'(wfull),         32'(n == DEPTH));
    chk({tag, ".rempty"},  32'(rempty),        32'(n == 0));
    chk({tag, ".afull"},   32'(walmost_full),  32'(n >= AF));
    chk({tag, ".aempty"},  32'(ralmost_empty), 32'(n <= AE));
    chk({tag, ".ovf"},     32'(overflow),      32'(m_ovf));
    chk({tag, ".udf"},     32'(underflow),     32'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  // Drive one clock of stimulus, advance the model, then check all outputs.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r,
                       input logic c, input string tag);
    bit full, empty;
    winc = w; wdata = d; rinc = r; clr_err = c;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    @(posedge wclk);
    #1;
    m_rvalid = r && !empty;
    if (m_rvalid) m_rdata = q.pop_front();
    if (w && !full) q.push_back(d);
    if (w && full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && empty) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic drain();
    while (q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    cycle(1'b0, '0, 1'b0, 1'b1, "clr");
  endtask

  initial begin
    logic [W-1:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    // Reset state
    #12;
    model_reset();
    check_all("reset");
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill to full, then drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, fill[i], 1'b0, 1'b0, "fill");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, "read");
      chk("read_order", 32'(rdata), 32'(fill[i]));
    end

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 8'($urandom), 1'((i % 3) != 0), 1'b0, "wrap");
    drain();

    // Random traffic including error events and clears
    for (int i = 0; i < 120; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), "rand");
    drain();

    // Full with simultaneous write and read: write dropped
    for (int i = 0; i < 4; i++) cycle(1'b1, fill[i], 1'b0, 1'b0, "fill2");
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, "ovf");
    chk("ovf_rdata", 32'(rdata), 32'h11);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd3);
    cycle(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf_cleared", 32'(overflow), 32'd0);
    drain();

    // Empty with simultaneous write and read: read rejected
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, "udf");
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_rvalid", 32'(rvalid), 32'd0);
    chk("udf_count", 32'(count), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, "udf_rd");
    chk("udf_rdata", 32'(rdata), 32'h5A);
    // Error set must win over a same-cycle clear
    cycle(1'b0, '0, 1'b1, 1'b1, "set_wins");
    chk("set_wins_udf", 32'(underflow), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, "clr2");

    // Asynchronous reset mid-stream at count 2 with a read in flight
    cycle(1'b1, 8'h61, 1'b0, 1'b0, "pre_rst");
    cycle(1'b1, 8'h62, 1'b0, 1'b0, "pre_rst");
    cycle(1'b1, 8'h63, 1'b1, 1'b0, "pre_rst");
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    wrst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge wclk);
    wrst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0, "post_rst_wr");
    cycle(1'b0, '0, 1'b1, 1'b0, "post_rst_rd");
    chk("post_rst_data", 32'(rdata), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo_buf.md
SYNC_FIFO_BUF -- requirements
Module: sync_fifo_buf

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: address bits; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-4: count at or above which walmost_full asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 4: count at or below which ralmost_empty asserts.
REQ-005 SHALL have port wclk  input  1: the single clock; all logic rising-edge.
REQ-006 SHALL have port wrst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port winc  input  1: write request.
REQ-008 SHALL have port wdata  input  FIFO_WIDTH: write data.
REQ-009 SHALL have port rinc  input  1: read request.
REQ-010 SHALL have port clr_err  input  1: synchronous clear of the sticky error flags.
REQ-011 SHALL have port rdata  output  FIFO_WIDTH: registered read data.
REQ-012 SHALL have port rvalid  output  1: rdata is valid this cycle.
REQ-013 SHALL have port wfull, rempty, walmost_full, ralmost_empty  output  1 each: status flags.
REQ-014 SHALL have port count  output  ADDR_WIDTH+1: current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow  output  1 each: sticky error flags.

Function
REQ-016 SHALL keep write and read pointers ADDR_WIDTH+1 bits wide; low ADDR_WIDTH bits address storage; the MSB is the wrap bit; pointers wrap modulo 2**(ADDR_WIDTH+1).
REQ-017 SHALL accept a write iff winc && !wfull; an accepted write stores wdata at wptr and increments wptr at that edge.
REQ-018 SHALL accept a read iff rinc && !rempty; an accepted read increments rptr, and rdata holds mem[rptr] with rvalid=1 in the following cycle (1-cycle latency).
REQ-019 SHALL hold rdata at its last value and drive rvalid=0 in any cycle after a cycle with no accepted read.
REQ-020 SHALL derive wfull, rempty, walmost_full, ralmost_empty and count from registered pointers only: count = wptr - rptr; wfull = (count == DEPTH); rempty = (count == 0); walmost_full = (count >= AFULL_LVL); ralmost_empty = (count <= AEMPTY_LVL).
REQ-021 SHALL, on simultaneous accepted write and read, leave count unchanged and update both pointers.
REQ-022 SHALL, when full with winc && rinc, accept the read, drop the write, and set overflow; count becomes DEPTH-1.
REQ-023 SHALL, when empty with winc && rinc, accept the write, reject the read, and set underflow; no read-through of the same-cycle wdata.
REQ-024 SHALL set overflow on any winc while wfull and underflow on any rinc while rempty; both remain set until clr_err or reset; set wins over clr_err in the same cycle.
REQ-025 SHALL never modify storage or pointers on a rejected request.

Reset
REQ-026 SHALL, while wrst_n=0, force wptr=0, rptr=0, rdata=0, rvalid=0, overflow=0, underflow=0; thus count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0.
REQ-027 SHALL abandon any in-flight read on reset mid-operation; storage contents need not be cleared.
REQ-028 SHALL resume operation on the first rising wclk after wrst_n deasserts.

Structure
REQ-029 SHALL place in shared package fifo_pkg: default width/depth constants and a function computing occupancy from two (ADDR_WIDTH+1)-bit pointers.
REQ-030 SHALL instantiate storage as one sub-module sync_ram_2p: one write port, one registered read port, no reset on the array.
REQ-031 SHALL reject at elaboration AFULL_LVL > DEPTH or AEMPTY_LVL >= DEPTH.

Verification (bench: FIFO_WIDTH=8, ADDR_WIDTH=2, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-032 SHALL cover: reset, write 0x11,0x22,0x33,0x44 -> count 1..4, walmost_full at count 3, wfull at 4, ralmost_empty drops at count 2.
REQ-033 SHALL cover: from full, four reads -> rdata 0x11,0x22,0x33,0x44 each one cycle after rinc with rvalid=1; rempty=1 after the last.
REQ-034 SHALL cover: 10 writes and 10 reads interleaved across pointer wrap -> data order preserved, no flag glitch, count never exceeds 4.
REQ-035 SHALL cover: full plus winc=rinc=1 with wdata=0xAA -> 0x11 read, 0xAA dropped, overflow=1, count=3; clr_err pulse -> overflow=0.
REQ-036 SHALL cover: empty plus winc=rinc=1 with wdata=0x5A -> underflow=1, rvalid=0 next cycle, count=1, next read returns 0x5A.
REQ-037 SHALL cover: wrst_n asserted mid-stream at count=2 -> all outputs at reset values immediately, without waiting for a clock edge.
